// File: rtl/axil_settings_pkg.sv
// Shared types and constants for the AXI4-Lite to settings-bus bridge.
package axil_settings_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STROBE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SAMPLE,
    R_RESP
  } rd_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axil_settings_bridge.sv
// AXI4-Lite slave to settings-bus bridge with independent write and read FSMs.
// Define AXIL_SETTINGS_SLVERR_EN to reject non-word-aligned accesses with SLVERR.
module axil_settings_bridge
  import axil_settings_pkg::*;
#(
  parameter int C_DATAWIDTH = 32,
  parameter int C_ADDRWIDTH = 32,
  parameter int C_PAGEWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [C_ADDRWIDTH-1:0]   s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [C_DATAWIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATAWIDTH/8-1:0] s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [C_ADDRWIDTH-1:0]   s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [C_DATAWIDTH-1:0]   s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [C_DATAWIDTH-1:0]   set_data,
  output logic [C_ADDRWIDTH-1:0]   set_addr,
  output logic                     set_stb,
  output logic [C_ADDRWIDTH-1:0]   get_addr,
  input  logic [C_DATAWIDTH-1:0]   get_data
);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic ready_en;
  logic aw_done, w_done;
  logic wr_err, rd_err;
  logic aw_hs, w_hs, ar_hs;
  logic aw_misaligned, ar_misaligned;

  // Every write is full-word; byte strobes carry no information here.
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

`ifdef AXIL_SETTINGS_SLVERR_EN
  assign aw_misaligned = |s_axi_awaddr[1:0];
  assign ar_misaligned = |s_axi_araddr[1:0];
`else
  assign aw_misaligned = 1'b0;
  assign ar_misaligned = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = OKAY;
    set_stb       = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi_awready = ready_en && !aw_done;
        s_axi_wready  = ready_en && !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_STROBE;
      end
      W_STROBE: begin
        set_stb = !wr_err;
        w_next  = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = wr_err ? SLVERR : OKAY;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rresp   = OKAY;
    unique case (r_state)
      R_IDLE: begin
        s_axi_arready = ready_en;
        if (ar_hs) r_next = R_SAMPLE;
      end
      R_SAMPLE: r_next = R_RESP;
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = rd_err ? SLVERR : OKAY;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Readies stay low through reset and come up one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      wr_err      <= 1'b0;
      rd_err      <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      get_addr    <= '0;
      s_axi_rdata <= '0;
    end else begin
      ready_en <= 1'b1;
      // Capture flags clear as soon as the pair is complete and the strobe launches.
      aw_done  <= (aw_done || aw_hs) && (w_next == W_IDLE);
      w_done   <= (w_done || w_hs) && (w_next == W_IDLE);
      if (aw_hs) begin
        set_addr <= s_axi_awaddr;
        wr_err   <= aw_misaligned;
      end
      if (w_hs) set_data <= s_axi_wdata;
      if (ar_hs) begin
        get_addr <= s_axi_araddr;
        rd_err   <= ar_misaligned;
      end
      if (r_state == R_SAMPLE) s_axi_rdata <= rd_err ? '0 : get_data;
    end
  end

endmodule

// File: tb/tb_axil_settings_bridge.sv
// Directed self-checking bench for axil_settings_bridge; honours AXIL_SETTINGS_SLVERR_EN.
module tb_axil_settings_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] set_data;
  logic [31:0] set_addr;
  logic        set_stb;
  logic [31:0] get_addr;
  logic [31:0] get_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axil_settings_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
    .get_addr(get_addr), .get_data(get_data)
  );

  task automatic test_reset;
    #2;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, set_stb} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, set_stb});
    end
    checks++;
    if ({set_data, set_addr, get_addr, s_axi_rdata, s_axi_bresp, s_axi_rresp} !== '0) begin
      failures++;
      $display("FAIL reset_data set_data=%h set_addr=%h get_addr=%h rdata=%h bresp=%b rresp=%b",
               set_data, set_addr, get_addr, s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    #20 rst_n = 1'b1;  // t=22, between edges
    #1;
    checks++;
    if (s_axi_awready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_clock awready=%b want=0", s_axi_awready);
    end
    @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_release got=%b want=111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_write_same_cycle;
    s_axi_awaddr = 32'h004; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_001A; s_axi_wvalid = 1'b1;
    s_axi_wstrb = 4'h1;  // strobes must be ignored
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wstrb = 4'hF;
    checks++;
    if ({set_stb, s_axi_bvalid, s_axi_awready} !== 3'b100 || set_addr !== 32'h004 || set_data !== 32'h1A) begin
      failures++;
      $display("FAIL wr_cycle1 stb/bvalid/awready=%b addr=%h data=%h want 100 004 0000001a",
               {set_stb, s_axi_bvalid, s_axi_awready}, set_addr, set_data);
    end
    @(negedge clk);
    checks++;
    if ({set_stb, s_axi_bvalid} !== 2'b01 || s_axi_bresp !== 2'b00) begin
      failures++;
      $display("FAIL wr_cycle2 stb/bvalid=%b bresp=%b want 01 00", {set_stb, s_axi_bvalid}, s_axi_bresp);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    checks++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
      failures++;
      $display("FAIL wr_done bvalid/awready/wready=%b want 011", {s_axi_bvalid, s_axi_awready, s_axi_wready});
    end
  endtask

  task automatic test_w_before_aw;
    int stb_early = 0;
    s_axi_wdata = 32'hCAFE_0001; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    checks++;
    if ({s_axi_wready, s_axi_awready} !== 2'b01) begin
      failures++;
      $display("FAIL w_first_ready wready/awready=%b want 01", {s_axi_wready, s_axi_awready});
    end
    for (int i = 0; i < 3; i++) begin
      if (set_stb) stb_early++;
      if (i < 2) @(negedge clk);
    end
    checks++;
    if (stb_early !== 0) begin
      failures++;
      $display("FAIL w_first_early_stb count=%0d want 0", stb_early);
    end
    s_axi_awaddr = 32'h020; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    checks++;
    if (set_stb !== 1'b1 || set_addr !== 32'h020 || set_data !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL w_first_stb stb=%b addr=%h data=%h want 1 020 cafe0001", set_stb, set_addr, set_data);
    end
    @(negedge clk);
    checks++;
    if ({set_stb, s_axi_bvalid} !== 2'b01 || s_axi_bresp !== 2'b00) begin
      failures++;
      $display("FAIL w_first_resp stb/bvalid=%b bresp=%b want 01 00", {set_stb, s_axi_bvalid}, s_axi_bresp);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic test_read_backpressure;
    get_data = 32'hACE0_BA53;
    s_axi_araddr = 32'h000; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    checks++;
    if ({s_axi_rvalid, s_axi_arready} !== 2'b00 || get_addr !== 32'h000) begin
      failures++;
      $display("FAIL rd_cycle1 rvalid/arready=%b get_addr=%h want 00 0", {s_axi_rvalid, s_axi_arready}, get_addr);
    end
    @(negedge clk);
    get_data = 32'h0;  // sample already taken; rdata must not follow
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hACE0_BA53 || s_axi_rresp !== 2'b00) begin
      failures++;
      $display("FAIL rd_cycle2 rvalid=%b rdata=%h rresp=%b want 1 ace0ba53 00",
               s_axi_rvalid, s_axi_rdata, s_axi_rresp);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_arready !== 1'b0 || s_axi_rdata !== 32'hACE0_BA53) begin
        failures++;
        $display("FAIL rd_hold[%0d] rvalid=%b arready=%b rdata=%h want 1 0 ace0ba53",
                 i, s_axi_rvalid, s_axi_arready, s_axi_rdata);
      end
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    checks++;
    if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
      failures++;
      $display("FAIL rd_done rvalid/arready=%b want 01", {s_axi_rvalid, s_axi_arready});
    end
  endtask

  task automatic test_concurrent;
    get_data = 32'h0BAD_F00D;
    s_axi_awaddr = 32'h008; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0055; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h00C; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++;
    if ({set_stb, s_axi_bvalid, s_axi_rvalid} !== 3'b100 || set_addr !== 32'h008
        || set_data !== 32'h55 || get_addr !== 32'h00C) begin
      failures++;
      $display("FAIL cc_cycle1 stb/bvalid/rvalid=%b set_addr=%h set_data=%h get_addr=%h want 100 008 55 00c",
               {set_stb, s_axi_bvalid, s_axi_rvalid}, set_addr, set_data, get_addr);
    end
    @(negedge clk);
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b11 || s_axi_rdata !== 32'h0BAD_F00D
        || s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      failures++;
      $display("FAIL cc_cycle2 bvalid/rvalid=%b rdata=%h bresp=%b rresp=%b want 11 0badf00d 00 00",
               {s_axi_bvalid, s_axi_rvalid}, s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready} !== 4'b0011) begin
      failures++;
      $display("FAIL cc_done bvalid/rvalid/awready/arready=%b want 0011",
               {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready});
    end
  endtask

  task automatic test_reset_mid_write;
    int stb_after = 0;
    s_axi_awaddr = 32'h010; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0077; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axi_bvalid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre bvalid=%b want 1", s_axi_bvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_axi_bvalid, s_axi_awready} !== 2'b00 || set_addr !== 32'h0 || set_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_async bvalid/awready=%b set_addr=%h set_data=%h want 00 0 0",
               {s_axi_bvalid, s_axi_awready}, set_addr, set_data);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL rst_mid_release awready/wready/bvalid=%b want 110",
               {s_axi_awready, s_axi_wready, s_axi_bvalid});
    end
    for (int i = 0; i < 4; i++) begin
      if (set_stb) stb_after++;
      @(negedge clk);
    end
    checks++;
    if (stb_after !== 0) begin
      failures++;
      $display("FAIL rst_mid_spurious_stb count=%0d want 0", stb_after);
    end
  endtask

  task automatic test_misaligned;
`ifdef AXIL_SETTINGS_SLVERR_EN
    logic        exp_stb = 1'b0;
    logic [1:0]  exp_resp = 2'b10;
    logic [31:0] exp_rdata = 32'h0;
`else
    logic        exp_stb = 1'b1;
    logic [1:0]  exp_resp = 2'b00;
    logic [31:0] exp_rdata = 32'hFFFF_FFFF;
`endif
    get_data = 32'hFFFF_FFFF;
    s_axi_awaddr = 32'h006; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0099; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h001; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++;
    if (set_stb !== exp_stb) begin
      failures++;
      $display("FAIL mis_stb stb=%b want %b", set_stb, exp_stb);
    end
    @(negedge clk);
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp) begin
      failures++;
      $display("FAIL mis_bresp bvalid=%b bresp=%b want 1 %b", s_axi_bvalid, s_axi_bresp, exp_resp);
    end
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== exp_resp || s_axi_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL mis_read rvalid=%b rresp=%b rdata=%h want 1 %b %h",
               s_axi_rvalid, s_axi_rresp, s_axi_rdata, exp_resp, exp_rdata);
    end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_backpressure();
    test_concurrent();
    test_misaligned();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_settings_bridge.md
AXIL_SETTINGS_BRIDGE -- requirements
Module: axil_settings_bridge

Interface
REQ-001 SHALL have parameter C_DATAWIDTH, default 32, settings/AXI data width.
REQ-002 SHALL have parameter C_ADDRWIDTH, default 32, AXI and settings address width.
REQ-003 SHALL have parameter C_PAGEWIDTH, default 12, byte-address bits decoded by the downstream settings block.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1, sole clock; rst_n input 1, async assert, active-low.
REQ-005 SHALL have ports: s_axi_awaddr in C_ADDRWIDTH; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-006 SHALL have ports: s_axi_wdata in C_DATAWIDTH; s_axi_wstrb in C_DATAWIDTH/8; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-007 SHALL have ports: s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-008 SHALL have ports: s_axi_araddr in C_ADDRWIDTH; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-009 SHALL have ports: s_axi_rdata out C_DATAWIDTH; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-010 SHALL have ports: set_data out C_DATAWIDTH; set_addr out C_ADDRWIDTH; set_stb out 1 (one-cycle write pulse); get_addr out C_ADDRWIDTH; get_data in C_DATAWIDTH (combinational readback from settings block).

Function
REQ-011 SHALL run independent write and read FSMs; simultaneous read and write proceed concurrently.
REQ-012 Write FSM SHALL have states W_IDLE, W_STROBE, W_RESP.
REQ-013 In W_IDLE, awready=1 until AW captured, wready=1 until W captured; AW and W accepted in either order or same cycle.
REQ-014 When both captured, SHALL go to W_STROBE: set_stb=1 for exactly one cycle with captured set_addr/set_data.
REQ-015 Then W_RESP: bvalid=1, bresp=OKAY, held until bready; return to W_IDLE the cycle after handshake.
REQ-016 Write latency: AW+W accepted cycle 0 -> set_stb cycle 1 -> bvalid cycle 2.
REQ-017 wstrb SHALL be ignored; every write is full-word.
REQ-018 Read FSM SHALL have states R_IDLE, R_SAMPLE, R_RESP; arready=1 only in R_IDLE.
REQ-019 On AR handshake, get_addr SHALL load araddr; R_SAMPLE lasts one cycle and captures get_data into rdata at its end.
REQ-020 R_RESP: rvalid=1, rresp=OKAY, rdata stable until rready; back to R_IDLE next cycle.
REQ-021 Read latency: AR accepted cycle 0 -> get_addr valid cycle 1 -> rvalid cycle 2.
REQ-022 get_addr, set_addr, set_data SHALL hold last value between transactions.
REQ-023 Back-pressure: no new AW/W/AR accepted while respective FSM is not idle.

Reset
REQ-024 On rst_n low, both FSMs SHALL return to idle immediately, aborting any transaction mid-flight.
REQ-025 Reset values: awready, wready, arready, bvalid, rvalid, set_stb = 0; bresp, rresp = 0; set_data, set_addr, get_addr, rdata = 0; capture flags cleared.
REQ-026 Ready signals SHALL rise the first clock after rst_n deasserts.

Configuration
REQ-027 Macro AXIL_SETTINGS_SLVERR_EN: defined -> write with awaddr[1:0]!=0 SHALL skip set_stb and return bresp=SLVERR; read with araddr[1:0]!=0 returns rresp=SLVERR, rdata=0; timing unchanged.
REQ-028 Undefined -> address low bits are ignored; all responses OKAY.

Structure
REQ-029 Shared package axil_settings_pkg SHALL hold write/read FSM state enums and response constants OKAY=2'b00, SLVERR=2'b10.
REQ-030 No sub-module; both FSMs live in axil_settings_bridge.

Verification
REQ-031 Write 0x004 data 0x0000001A, AW and W same cycle -> set_stb one cycle at cycle 1, set_addr=0x004, set_data=0x1A, bvalid cycle 2, bresp=0.
REQ-032 W presented 3 cycles before AW -> exactly one set_stb, after AW accept; bresp OKAY.
REQ-033 Read 0x000 with get_data driven 0xACE0BA53 -> rvalid cycle 2, rdata=0xACE0BA53; rready held low 5 cycles -> rdata stable, arready=0.
REQ-034 Concurrent write 0x008 and read 0x00C same cycle -> both complete, latencies per REQ-016/REQ-021.
REQ-035 rst_n low during W_RESP -> bvalid drops asynchronously; after release awready=1, no spurious set_stb.
REQ-036 With AXIL_SETTINGS_SLVERR_EN, write 0x006 -> no set_stb, bresp=2'b10; read 0x001 -> rresp=2'b10, rdata=0.
